// File: rtl/tdm_wavetable_sequencer_if.sv
// rtl/tdm_wavetable_sequencer_if.sv - frame/sample bus between NCO side, wavetable sequencer and mixer
//
// Purpose: bundles the per-frame voice snapshot inputs and the tagged sample stream.
// Signals:
//   frame_start     1-cycle pulse requesting a new sweep
//   voice_addr_in   packed phase addresses, voice v at [v*ADDR_BITS +: ADDR_BITS]
//   voice_wave_sel  packed table selects, voice v at [v*WAVE_BITS +: WAVE_BITS]
//   voice_enable    per-voice enable
//   busy            sweep in progress
//   sample_valid    sample_voice/sample_d_out valid
//   sample_voice    voice index of the sample
//   sample_d_out    table sample (zero for a disabled voice)
//   frame_done      pulse with the last sample of a frame
// Modports: master drives the frame inputs, slave is the sequencer.
interface tdm_wavetable_sequencer_if #(
  parameter int D_W         = 16,
  parameter int VOICES      = 8,
  parameter int VOICES_BITS = 3,
  parameter int ADDR_BITS   = 8,
  parameter int WAVE_BITS   = 2
);
  logic                          frame_start;
  logic [VOICES*ADDR_BITS-1:0]   voice_addr_in;
  logic [VOICES*WAVE_BITS-1:0]   voice_wave_sel;
  logic [VOICES-1:0]             voice_enable;
  logic                          busy;
  logic                          sample_valid;
  logic [VOICES_BITS-1:0]        sample_voice;
  logic [D_W-1:0]                sample_d_out;
  logic                          frame_done;

  modport master (
    output frame_start, voice_addr_in, voice_wave_sel, voice_enable,
    input  busy, sample_valid, sample_voice, sample_d_out, frame_done
  );

  modport slave (
    input  frame_start, voice_addr_in, voice_wave_sel, voice_enable,
    output busy, sample_valid, sample_voice, sample_d_out, frame_done
  );
endinterface

// File: rtl/tdm_wavetable_sequencer.sv
// rtl/tdm_wavetable_sequencer.sv - time-division multi-voice wavetable reader
//
// Purpose: on frame_start, snapshots every voice's phase address, wave select and
// enable, then sweeps the voices one per clock through one stacked wavetable ROM
// and streams tagged samples (voice 0..VOICES-1, no gaps) to the mixer.
// Ports:
//   sys_clk   system clock
//   sys_rst   synchronous active-high reset
//   bus       tdm_wavetable_sequencer_if.slave (frame inputs, sample stream, busy)
// Timing: frame_start in cycle T -> voice v valid in T+3+v, frame_done in
// T+2+VOICES, busy high T+1..T+2+VOICES.
module tdm_wavetable_sequencer #(
  parameter int    D_W         = 16,
  parameter int    VOICES      = 8,
  parameter int    VOICES_BITS = 3,
  parameter int    ADDR_BITS   = 8,
  parameter int    WAVES       = 4,
  parameter int    WAVE_BITS   = 2,
  parameter string TABLE_FILE  = "wavetables_16x1024.mem"
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  tdm_wavetable_sequencer_if.slave  bus
);

  localparam int ROM_AW    = WAVE_BITS + ADDR_BITS;
  localparam int ROM_WORDS = WAVES << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [VOICES_BITS-1:0]      issue_q, issue_d;
  logic                        drain_q, drain_d;
  logic                        accept;
  logic                        issue;

  logic [VOICES*ADDR_BITS-1:0] addr_sh;
  logic [VOICES*WAVE_BITS-1:0] wave_sh;
  logic [VOICES-1:0]           en_sh;

  logic [ADDR_BITS-1:0]        cur_addr;
  logic [WAVE_BITS-1:0]        cur_wave;

  logic                        s0_valid;
  logic [VOICES_BITS-1:0]      s0_voice;
  logic                        s0_en;
  logic [ROM_AW-1:0]           rom_addr_q;
  logic [D_W-1:0]              rom_rd;

  logic                        out_valid;
  logic [VOICES_BITS-1:0]      out_voice;
  logic [D_W-1:0]              out_data;
  logic                        out_done;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      drain_q <= drain_d;
    end
  end

  // FSM next state; frame_start only counts in IDLE, so pulses while busy are dropped
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    drain_d = drain_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          accept  = 1'b1;
          issue_d = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        issue   = 1'b1;
        issue_d = issue_q + 1'b1;
        if (issue_q == VOICES_BITS'(VOICES - 1)) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot shadows: the sweep reads only these, never the live inputs
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      addr_sh <= bus.voice_addr_in;
      wave_sh <= bus.voice_wave_sel;
      en_sh   <= bus.voice_enable;
    end
  end

  always_comb begin
    cur_addr = addr_sh[issue_q*ADDR_BITS +: ADDR_BITS];
    // Out-of-range selects fold back onto an existing table
    cur_wave = WAVE_BITS'(int'(wave_sh[issue_q*WAVE_BITS +: WAVE_BITS]) % WAVES);
  end

  // Stage 0: ROM address register with voice tag and enable riding alongside
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s0_valid   <= 1'b0;
      s0_voice   <= '0;
      s0_en      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      s0_valid <= issue;
      if (issue) begin
        rom_addr_q <= {cur_wave, cur_addr};
        s0_voice   <= issue_q;
        s0_en      <= en_sh[issue_q];
      end
    end
  end

  // Stage 1: ROM array read from the registered address
  function automatic logic [D_W-1:0] image_word(input logic [ROM_AW-1:0] idx);
    image_word = (D_W'(idx[ROM_AW-1:ADDR_BITS]) << 12) + D_W'(idx[ADDR_BITS-1:0]);
  endfunction

  logic [D_W-1:0] rom [ROM_WORDS];

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) begin
      rom[i] = image_word(ROM_AW'(i));
    end
  end

  assign rom_rd = rom[rom_addr_q];

  // Stage 2: output register; disabled voices keep their slot but read as zero.
  // Data/voice hold their last value while invalid.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      out_voice <= '0;
      out_data  <= '0;
      out_done  <= 1'b0;
    end else begin
      out_valid <= s0_valid;
      out_done  <= s0_valid && (s0_voice == VOICES_BITS'(VOICES - 1));
      if (s0_valid) begin
        out_voice <= s0_voice;
        out_data  <= s0_en ? rom_rd : '0;
      end
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.sample_valid = out_valid;
  assign bus.sample_voice = out_voice;
  assign bus.sample_d_out = out_data;
  assign bus.frame_done   = out_done;

endmodule

// File: tb/tb_tdm_wavetable_sequencer.sv
// tb/tb_tdm_wavetable_sequencer.sv - scoreboard bench for tdm_wavetable_sequencer
module tb_tdm_wavetable_sequencer;

  localparam int D_W = 16;
  localparam int VOICES = 8;
  localparam int VOICES_BITS = 3;
  localparam int ADDR_BITS = 8;
  localparam int WAVES = 4;
  localparam int WAVE_BITS = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  tdm_wavetable_sequencer_if #(
    .D_W(D_W), .VOICES(VOICES), .VOICES_BITS(VOICES_BITS),
    .ADDR_BITS(ADDR_BITS), .WAVE_BITS(WAVE_BITS)
  ) bus ();

  tdm_wavetable_sequencer #(
    .D_W(D_W), .VOICES(VOICES), .VOICES_BITS(VOICES_BITS), .ADDR_BITS(ADDR_BITS),
    .WAVES(WAVES), .WAVE_BITS(WAVE_BITS), .TABLE_FILE("")
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  voice;
    logic [15:0] data;
    logic        done;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Hand-computed expectations for image word {w,a} = 16'h1000*w + a
  logic [15:0] t1_exp [8] = '{16'h0000, 16'h1010, 16'h2020, 16'h3030,
                              16'h0040, 16'h1050, 16'h2060, 16'h3070};
  logic [15:0] t2_exp [8] = '{16'h0000, 16'h1010, 16'h0000, 16'h3030,
                              16'h0000, 16'h1050, 16'h0000, 16'h3070};
  logic [15:0] t3_exp [8] = '{16'h30FF, 16'h0000, 16'h2080, 16'h00FF,
                              16'h1001, 16'h1001, 16'h1001, 16'h1001};
  logic [15:0] t4b_exp [8] = '{16'h30A0, 16'h30A1, 16'h30A2, 16'h30A3,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};

  logic [63:0] t1_a, t3_a, t4b_a;
  logic [15:0] t1_s, t3_s, t4b_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input int t, input logic [15:0] exp_d [8], input int nv);
    exp_t e;
    for (int v = 0; v < nv; v++) begin
      e.cyc   = t + 3 + v;
      e.voice = 3'(v);
      e.data  = exp_d[v];
      e.done  = (v == VOICES - 1);
      expq.push_back(e);
    end
  endtask

  // Drive one frame_start pulse in the current cycle; returns with cyc = T+1
  task automatic launch(input logic [63:0] a, input logic [15:0] s, input logic [7:0] en,
                        input logic [15:0] exp_d [8], input int nv, output int t);
    bus.voice_addr_in  = a;
    bus.voice_wave_sel = s;
    bus.voice_enable   = en;
    bus.frame_start    = 1'b1;
    t = cyc;
    push_exp(t, exp_d, nv);
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Monitor: pops one expectation per valid sample; frame_done must never appear alone
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (bus.sample_valid === 1'b1) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample actual=voice%0d/%h required=none (cycle %0d)",
                   bus.sample_voice, bus.sample_d_out, cyc);
        end else begin
          mon_e = expq.pop_front();
          check("sample_cycle", cyc, mon_e.cyc);
          check("sample_voice", 32'(bus.sample_voice), 32'(mon_e.voice));
          check("sample_data", 32'(bus.sample_d_out), 32'(mon_e.data));
          check("frame_done", 32'(bus.frame_done), 32'(mon_e.done));
        end
      end else begin
        check("idle_valid_known", 32'(bus.sample_valid), 32'd0);
        check("idle_frame_done", 32'(bus.frame_done), 32'd0);
      end
    end
  end

  initial begin
    int t;
    for (int v = 0; v < 8; v++) begin
      t1_a[v*8 +: 8] = 8'(v * 16);
      t1_s[v*2 +: 2] = 2'(v % 4);
      t3_a[v*8 +: 8] = 8'h01;
      t3_s[v*2 +: 2] = 2'd1;
      t4b_a[v*8 +: 8] = 8'(8'hA0 + v);
      t4b_s[v*2 +: 2] = 2'd3;
    end
    t3_a[7:0] = 8'hFF;  t3_s[1:0] = 2'd3;
    t3_a[15:8] = 8'h00; t3_s[3:2] = 2'd0;
    t3_a[23:16] = 8'h80; t3_s[5:4] = 2'd2;
    t3_a[31:24] = 8'hFF; t3_s[7:6] = 2'd0;

    bus.frame_start    = 1'b0;
    bus.voice_addr_in  = '0;
    bus.voice_wave_sel = '0;
    bus.voice_enable   = '0;
    sys_rst = 1'b1;
    tick();
    bus.frame_start = 1'b1;  // ignored under reset
    tick();
    bus.frame_start = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_voice", 32'(bus.sample_voice), 32'd0);
    check("rst_data", 32'(bus.sample_d_out), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    sys_rst = 1'b0;
    mon_en = 1'b1;
    tick();
    check("rst_start_ignored", 32'(bus.busy), 32'd0);
    tick();

    // T1: all voices enabled
    launch(t1_a, t1_s, 8'hFF, t1_exp, 8, t);
    check("t1_busy_first", 32'(bus.busy), 32'd1);
    repeat (9) tick();
    check("t1_busy_last", 32'(bus.busy), 32'd1);
    tick();
    check("t1_busy_clear", 32'(bus.busy), 32'd0);
    repeat (2) tick();

    // T2: even voices disabled
    launch(t1_a, t1_s, 8'b1010_1010, t2_exp, 8, t);
    repeat (12) tick();

    // T3: table-boundary addresses
    launch(t3_a, t3_s, 8'hFF, t3_exp, 8, t);
    repeat (12) tick();

    // T4: inputs changed after snapshot, pulses while busy ignored, T+11 accepted
    launch(t1_a, t1_s, 8'hFF, t1_exp, 8, t);
    bus.voice_addr_in  = t4b_a;
    bus.voice_wave_sel = t4b_s;
    bus.voice_enable   = 8'h0F;
    repeat (3) tick();
    bus.frame_start = 1'b1;          // T+4
    tick();
    bus.frame_start = 1'b0;
    repeat (5) tick();
    bus.frame_start = 1'b1;          // T+10, frame_done cycle
    tick();
    check("t4_idle_at_t11", 32'(bus.busy), 32'd0);
    push_exp(cyc, t4b_exp, 8);       // T+11 pulse accepted
    tick();
    bus.frame_start = 1'b0;
    check("t4_accept_t11", 32'(bus.busy), 32'd1);
    repeat (12) tick();

    // T5: reset at T+5 abandons the sweep
    launch(t1_a, t1_s, 8'hFF, t1_exp, 3, t);
    repeat (4) tick();
    sys_rst = 1'b1;                  // T+5
    tick();
    sys_rst = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_valid", 32'(bus.sample_valid), 32'd0);
    check("t5_data", 32'(bus.sample_d_out), 32'd0);
    check("t5_done", 32'(bus.frame_done), 32'd0);
    tick();
    launch(t3_a, t3_s, 8'hFF, t3_exp, 8, t);  // T+7
    repeat (12) tick();

    // T6: back-to-back frames at T and T+11
    launch(t1_a, t1_s, 8'b1010_1010, t2_exp, 8, t);
    repeat (10) tick();
    launch(t1_a, t1_s, 8'hFF, t1_exp, 8, t);
    repeat (14) tick();

    check("queue_empty", 32'(expq.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
